imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_WADDR, default 10'h080, first instruction-memory word address written (byte address 0x200, the core reset PC).
REQ-002 Parameter MAX_WORDS, default 896, largest accepted word count (words from BASE_WADDR to 10'h3FF).
REQ-003 Clock and reset: one clock, clk; reset rst, asynchronous, active-low.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load session.
REQ-007 rx_data  input  8  incoming program byte.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready at clk edge.
REQ-010 mem_address  output  10  instruction-memory word address.
REQ-011 mem_data  output  32  instruction word to write.
REQ-012 mem_wren  output  1  instruction-memory write enable, one cycle per word.
REQ-013 core_rst  output  1  active-low reset to the core; low holds core in reset.
REQ-014 busy  output  1  load session in progress.
REQ-015 done  output  1  last session completed with good checksum.
REQ-016 error  output  1  last session aborted.
REQ-017 words_loaded  output  10  words written in current/last session.

Function
REQ-018 States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, CKSUM, DONE, ERROR; all outputs registered or decoded from state only.
REQ-019 Stream format: count low byte, count high byte (16-bit N, little-endian), then N*4 data bytes, then one checksum byte.
REQ-020 IDLE/DONE/ERROR + start -> HDR_LO; clear words_loaded, checksum accumulator, done, error; start ignored in all other states.
REQ-021 rx_ready = 1 only in HDR_LO, HDR_HI, DATA, CKSUM; 0 in IDLE, WRITE, DONE, ERROR.
REQ-022 HDR_LO: accepted byte -> N[7:0], go HDR_HI; HDR_HI: accepted byte -> N[15:8]; if N == 0 or N > MAX_WORDS go ERROR, else DATA.
REQ-023 DATA: bytes assembled little-endian (first byte -> word[7:0], fourth -> word[31:24]); on fourth accepted byte go WRITE; byte counter wraps 3 -> 0.
REQ-024 WRITE: exactly one cycle, mem_wren = 1, mem_address = BASE_WADDR + words_loaded, mem_data = assembled word; words_loaded increments at end of cycle; next CKSUM if incremented count == N, else DATA.
REQ-025 mem_wren = 0 in every state except WRITE; mem_address/mem_data hold last value outside WRITE.
REQ-026 Checksum accumulator = XOR of every accepted header and data byte; CKSUM: accepted byte equal to accumulator -> DONE, else ERROR.
REQ-027 core_rst = 1 in IDLE and DONE; 0 in HDR_LO, HDR_HI, DATA, WRITE, CKSUM, ERROR.
REQ-028 busy = 1 in HDR_LO..CKSUM; done = 1 only in DONE; error = 1 only in ERROR.
REQ-029 Words already written before ERROR remain in memory; no rollback.
REQ-030 rx_valid low for any number of cycles stalls the FSM in place, no timeout.
REQ-031 Address arithmetic 10-bit; MAX_WORDS check guarantees no wrap past 10'h3FF.

Reset
REQ-032 rst low: state IDLE, core_rst 0, rx_ready 0, mem_wren 0, mem_address 0, mem_data 0, busy 0, done 0, error 0, words_loaded 0, checksum 0, immediately and asynchronously.
REQ-033 First clk edge after rst high: core_rst -> 1 (IDLE).
REQ-034 rst low mid-session aborts immediately; any in-progress WRITE cycle is suppressed.

Verification
REQ-035 Reset: assert rst low mid-clock -> all outputs at REQ-032 values before next edge; one edge after release core_rst = 1.
REQ-036 start; bytes 01 00 13 05 10 00 07 -> one mem_wren pulse, address 0x080, data 0x00100513; DONE, done = 1, core_rst = 1, words_loaded = 1.
REQ-037 start; header 00 00 -> ERROR, error = 1, core_rst = 0, no mem_wren; header 81 03 (N = 897) -> ERROR likewise.
REQ-038 start; 01 00 13 05 10 00 FF -> write to 0x080 occurs, then ERROR, error = 1, done = 0.
REQ-039 N = 2 with rx_valid held high continuously -> rx_ready low during each WRITE cycle, no byte lost; writes to 0x080 and 0x081 with correct words.
REQ-040 rst low after 2 of 4 data bytes -> no mem_wren, IDLE after release; fresh session then loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Receives a program image over a byte stream and writes it into instruction
// memory starting at BASE_WADDR, holding the core in reset while loading.
//
// Stream: count_lo, count_hi (N words, little-endian), N*4 data bytes
// (each word little-endian), then one XOR checksum byte covering all header
// and data bytes.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle request to begin a session (IDLE/DONE/ERROR only)
//   rx_data      incoming byte
//   rx_valid     rx_data valid
//   rx_ready     loader can accept a byte this cycle
//   mem_address  instruction-memory word address
//   mem_data     instruction word
//   mem_wren     write strobe, one cycle per word
//   core_rst     active-low core reset (high only in IDLE and DONE)
//   busy         session in progress
//   done         last session completed with a good checksum
//   error        last session aborted
//   words_loaded words written in the current/last session
//
// state  | meaning
// IDLE   | waiting for start, core released
// HDR_LO | waiting for count low byte
// HDR_HI | waiting for count high byte, range check on completion
// DATA   | assembling a 32-bit word from four bytes
// WRITE  | single-cycle memory write of the assembled word
// CKSUM  | waiting for checksum byte
// DONE   | image loaded and verified, core released
// ERROR  | session aborted, core held in reset

module imem_loader #(
  parameter logic [9:0] BASE_WADDR = 10'h080,
  parameter int         MAX_WORDS  = 896
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [9:0]  mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CKSUM  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [9:0]  words_q, words_d;
  logic [7:0]  cksum_q, cksum_d;

  logic        rx_ready_q;
  logic [9:0]  mem_address_q;
  logic [31:0] mem_data_q;
  logic        mem_wren_q;
  logic        core_rst_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic [15:0] hdr_count;

  // rx_ready_q mirrors the current state, so this is exactly the handshake
  // the sender sees.
  assign accept    = rx_valid && rx_ready_q;
  assign hdr_count = {rx_data, count_q[7:0]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    words_d    = words_q;
    cksum_d    = cksum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR_LO;
          count_d    = '0;
          byte_idx_d = '0;
          words_d    = '0;
          cksum_d    = '0;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          cksum_d      = cksum_q ^ rx_data;
          state_d      = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          cksum_d       = cksum_q ^ rx_data;
          // Range check also guarantees the 10-bit address never wraps.
          if (hdr_count == 16'd0 || hdr_count > 16'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // Shift in from the top: after four bytes the first one sits in [7:0].
          word_d     = {rx_data, word_q[31:8]};
          cksum_d    = cksum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 10'd1;
        if ({6'd0, words_d} == count_q) begin
          state_d = S_CKSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CKSUM: begin
        if (accept) begin
          state_d = (rx_data == cksum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      word_q        <= '0;
      byte_idx_q    <= '0;
      words_q       <= '0;
      cksum_q       <= '0;
      rx_ready_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      core_rst_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      words_q    <= words_d;
      cksum_q    <= cksum_d;

      rx_ready_q <= (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                    (state_d == S_DATA)   || (state_d == S_CKSUM);
      mem_wren_q <= (state_d == S_WRITE);
      core_rst_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy_q     <= (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                    (state_d == S_DATA)   || (state_d == S_WRITE)  ||
                    (state_d == S_CKSUM);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);

      // Entering WRITE: words_d still equals the pre-increment count.
      if (state_d == S_WRITE) begin
        mem_address_q <= BASE_WADDR + words_d;
        mem_data_q    <= word_d;
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = mem_wren_q;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  words_loaded;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int total = 0;
  int bad   = 0;

  // Write monitor: every strobed word, and whether rx_ready was ever seen
  // high during a write cycle.
  logic [41:0] act_wr[$];
  int          wr_rdy_hi = 0;
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_wren === 1'b1) begin
      act_wr.push_back({mem_address, mem_data});
      if (rx_ready !== 1'b0) wr_rdy_hi++;
    end
  end

  // Reference model state
  logic [7:0]  stream[$];
  logic [41:0] exp_wr[$];
  logic        exp_done;
  logic        exp_error;
  int          exp_words;
  int          exp_used;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the stream as the format describes it and derive the whole outcome.
  function automatic void build_model();
    int          n;
    logic [7:0]  cks;
    logic [31:0] w;
    exp_wr.delete();
    n = int'({stream[1], stream[0]});
    if (n == 0 || n > 896) begin
      exp_error = 1'b1;
      exp_done  = 1'b0;
      exp_words = 0;
      exp_used  = 2;
      return;
    end
    cks = stream[0] ^ stream[1];
    for (int i = 0; i < n; i++) begin
      w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      cks = cks ^ stream[2+4*i] ^ stream[2+4*i+1] ^ stream[2+4*i+2] ^ stream[2+4*i+3];
      exp_wr.push_back({10'(128 + i), w});
    end
    exp_used  = 2 + 4 * n + 1;
    exp_words = n;
    exp_done  = (stream[exp_used-1] == cks);
    exp_error = !exp_done;
  endfunction

  task automatic make_stream(input int n, input bit good_ck);
    logic [7:0] cks;
    logic [7:0] b;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    cks = n[7:0] ^ n[15:8];
    if (n >= 1 && n <= 896) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        cks ^= b;
      end
      if (!good_ck) cks ^= 8'($urandom_range(1, 255));
      stream.push_back(cks);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (rx_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) check("rx_handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic run_session(input string tag, input int maxgap);
    act_wr.delete();
    wr_rdy_hi = 0;
    build_model();
    pulse_start();
    for (int i = 0; i < exp_used; i++) begin
      send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    @(negedge clk); rx_valid = 1'b0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(exp_error));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(exp_done));
    check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
    check({tag, "_nwrites"}, 64'(act_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
      if (act_wr[i] !== exp_wr[i]) check({tag, "_write"}, 64'(act_wr[i]), 64'(exp_wr[i]));
    end
    check({tag, "_rdy_in_write"}, 64'(wr_rdy_hi), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_mem_wren"}, 64'(mem_wren), 64'd0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
    check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // Power-on reset
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("por_release_core_rst", 64'(core_rst), 64'd1);
    check("por_release_busy", 64'(busy), 64'd0);

    // Single word, good checksum
    stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
    run_session("one_word", 0);
    if (act_wr.size() > 0) check("one_word_exact", 64'(act_wr[0]), 64'({10'h080, 32'h00100513}));

    // Header rejects
    stream = '{8'h00, 8'h00};
    run_session("hdr_zero", 1);
    stream = '{8'h81, 8'h03};
    run_session("hdr_897", 1);

    // Bad checksum after a completed write
    stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hFF};
    run_session("bad_ck", 0);

    // Two words with rx_valid held high throughout
    make_stream(2, 1'b1);
    run_session("two_words_stream", 0);

    // Reset in the middle of a word
    act_wr.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_release_core_rst", 64'(core_rst), 64'd1);
    check("mid_rst_no_write", 64'(act_wr.size()), 64'd0);
    make_stream(3, 1'b1);
    run_session("after_rst", 1);

    // Largest image fills the top of memory
    make_stream(896, 1'b1);
    run_session("max_words", 0);

    // Randomized sessions
    for (int s = 0; s < 10; s++) begin
      case ($urandom_range(0, 5))
        0:       n = 0;
        1:       n = 897 + int'($urandom_range(0, 200));
        default: n = int'($urandom_range(1, 6));
      endcase
      make_stream(n, ($urandom_range(0, 2) != 0));
      run_session("rand", 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
